// File: rtl/metronomo_leds.sv
// rtl/metronomo_leds.sv - one-hot running-light beat generator for board LEDs
//
// Purpose: a single lit LED walks one position per rising clock edge across
// WIDTH LEDs and wraps from the MSB back to bit 0. Any tempo division is done
// upstream by whatever drives clk.
//
// Ports:
//   clk   in   1      system clock, all state changes on the rising edge
//   rst_n in   1      asynchronous active-low reset, forces LED 0 lit
//   leds  out  WIDTH  one-hot LED drive, bit i high lights LED i
//
// Parameters:
//   WIDTH  number of LEDs, legal range 1..32

module metronomo_leds #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] leds
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "metronomo_leds: WIDTH must be in 1..32");
    end

    localparam logic [WIDTH-1:0] L_BIT0 = WIDTH'(1);

    logic [WIDTH-1:0] r_leds;
    logic [WIDTH-1:0] w_rot;
    logic             w_onehot;
    logic [WIDTH-1:0] w_next;

    if (WIDTH == 1) begin : g_single
        assign w_rot = L_BIT0;
    end else begin : g_multi
        assign w_rot = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
    end

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign w_onehot = (r_leds != '0) && ((r_leds & (r_leds - L_BIT0)) == '0);

    // An upset that leaves zero or several lit LEDs is repaired on the next
    // edge by restarting from LED 0 instead of rotating the bad pattern.
    assign w_next = w_onehot ? w_rot : L_BIT0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= L_BIT0;
        end else begin
            r_leds <= w_next;
        end
    end

    assign leds = r_leds;

endmodule

// File: tb/tb_metronomo_leds.sv
// tb/tb_metronomo_leds.sv - self-checking bench for metronomo_leds

module tb_metronomo_leds;

    logic       clk;
    logic       rst_n;
    logic [1:0] leds2;
    logic [3:0] leds4;
    logic [0:0] leds1;

    metronomo_leds #(.WIDTH(2)) u_w2 (.clk(clk), .rst_n(rst_n), .leds(leds2));
    metronomo_leds #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .leds(leds4));
    metronomo_leds #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .leds(leds1));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: beat position of each instance, counted in clocks
    // since reset; expected LEDs are 1 << position.
    int widths [3] = '{2, 4, 1};
    int pos    [3];
    bit corrupt4;

    typedef struct {
        logic       rst;
        logic [1:0] e2;
        logic [3:0] e4;
        logic       e1;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: leds=%0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pos[i] = 0;
        corrupt4 = 1'b0;
    endtask

    task automatic model_edge();
        if (rst_n) begin
            for (int i = 0; i < 3; i++) pos[i] = (pos[i] + 1) % widths[i];
            if (corrupt4) pos[1] = 0;
            corrupt4 = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_of(input int i);
        return 32'd1 << pos[i];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_w2"}, 32'(leds2), exp_of(0));
        chk({tag, "_w4"}, 32'(leds4), exp_of(1));
        chk({tag, "_w1"}, 32'(leds1), exp_of(2));
    endtask

    // One clock: inputs change at the falling edge, outputs sampled 1 ns
    // after the rising edge.
    task automatic step(input logic r);
        @(negedge clk);
        rst_n = r;
        if (!r) model_reset();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        corrupt4 = 1'b0;
        rst_n = 1'b1;

        tbl[0]  = '{1'b0, 2'b01, 4'b0001, 1'b1};
        tbl[1]  = '{1'b0, 2'b01, 4'b0001, 1'b1};
        tbl[2]  = '{1'b0, 2'b01, 4'b0001, 1'b1};
        tbl[3]  = '{1'b0, 2'b01, 4'b0001, 1'b1};
        tbl[4]  = '{1'b0, 2'b01, 4'b0001, 1'b1};
        tbl[5]  = '{1'b1, 2'b10, 4'b0010, 1'b1};
        tbl[6]  = '{1'b1, 2'b01, 4'b0100, 1'b1};
        tbl[7]  = '{1'b1, 2'b10, 4'b1000, 1'b1};
        tbl[8]  = '{1'b1, 2'b01, 4'b0001, 1'b1};
        tbl[9]  = '{1'b1, 2'b10, 4'b0010, 1'b1};
        tbl[10] = '{1'b1, 2'b01, 4'b0100, 1'b1};
        tbl[11] = '{1'b1, 2'b10, 4'b1000, 1'b1};
        tbl[12] = '{1'b1, 2'b01, 4'b0001, 1'b1};
        tbl[13] = '{1'b1, 2'b10, 4'b0010, 1'b1};

        // Reset value before any clock edge.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("pre_clk_w2", 32'(leds2), 32'h1);
        chk("pre_clk_w4", 32'(leds4), 32'h1);
        chk("pre_clk_w1", 32'(leds1), 32'h1);

        // Table: 5 reset clocks, then 9 free-running clocks.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst);
            chk($sformatf("tbl%0d_w2", i), 32'(leds2), 32'(tbl[i].e2));
            chk($sformatf("tbl%0d_w4", i), 32'(leds4), 32'(tbl[i].e4));
            chk($sformatf("tbl%0d_w1", i), 32'(leds1), 32'(tbl[i].e1));
        end

        // Long alternation run.
        for (int i = 0; i < 25; i++) begin
            step(1'b1);
            check_all($sformatf("alt%0d", i));
        end

        // Randomized reset pattern against the model.
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
            check_all($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_onehot4", i), 32'($countones(leds4)), 32'd1);
        end

        // Asynchronous reset mid-run from position 3 of the 4-wide instance.
        step(1'b1);
        for (int i = 0; i < 4 && pos[1] != 3; i++) step(1'b1);
        chk("at_msb_w4", 32'(leds4), 32'h8);
        #4 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_w4", 32'(leds4), 32'h1);
        chk("async_rst_w2", 32'(leds2), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_hold_w4", 32'(leds4), 32'h1);
        @(posedge clk);
        #1;
        model_edge();
        chk("after_release_w4", 32'(leds4), 32'h2);
        check_all("after_release");

        // Corruption recovery: all-zero, then multi-bit.
        @(negedge clk);
        force u_w4.r_leds = 4'b0000;
        #1 release u_w4.r_leds;
        corrupt4 = 1'b1;
        @(posedge clk);
        #1;
        model_edge();
        chk("rec_zero_w4", 32'(leds4), 32'h1);
        step(1'b1);
        chk("rec_zero_next_w4", 32'(leds4), 32'h2);

        @(negedge clk);
        force u_w4.r_leds = 4'b0110;
        #1 release u_w4.r_leds;
        corrupt4 = 1'b1;
        @(posedge clk);
        #1;
        model_edge();
        chk("rec_multi_w4", 32'(leds4), 32'h1);
        step(1'b1);
        chk("rec_multi_next_w4", 32'(leds4), 32'h2);
        check_all("rec_multi_next");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/metronomo_leds.md
Name: metronomo_leds

Overview:
- Visual metronome beat generator: a one-hot "running light" over WIDTH LEDs.
- Advances one position on every rising clock edge and wraps from the MSB back to bit 0.
- Sits directly on the board LED pins. Beat rate equals the clock rate, so any tempo division happens upstream in the clock/enable source.

Parameters:
- WIDTH, 2, number of LEDs (bits of `leds`); legal range 1..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- leds  output  WIDTH  one-hot LED drive; bit i high means LED i is lit.

Behaviour:
- Reset: while rst_n = 0, leds = {WIDTH-1 zeros, 1} (only bit 0 set), asynchronously.
  - Takes effect immediately on the falling edge of rst_n, with no clock required.
  - Held for as long as rst_n is low.
- Reset release: no change at release itself; leds stays at bit 0 until the first rising clk edge with rst_n = 1.
- Advance: on each rising clk edge with rst_n = 1, leds rotates left by one.
  - New value is {leds[WIDTH-2:0], leds[WIDTH-1]}.
  - Equivalently, position p becomes (p+1) mod WIDTH.
  - No enable, no stall: exactly one step per clock.
- Latency: leds is a registered output, updated on the clock edge and stable for the whole following cycle. No combinational path from any input to leds.
- Wrap-around: from bit WIDTH-1 set, the next edge returns to bit 0 set.
- Sequence for WIDTH=2: 01 at reset, then 10, 01, 10, ... alternating every clock.
- After k clocks post-reset: leds = 1 << (k mod WIDTH).
- WIDTH = 1: leds is constantly 1 (rotation is the identity).
- Robustness: if the state is ever not exactly one-hot (all-zero or multi-bit, e.g. an upset), the next rising edge forces leds to bit 0 set. Rotation continues normally from there.
- Reset mid-operation: assertion at any time overrides the clock and forces bit 0, independent of current position.
- Invariant: outside the single cycle after a corrupted state, exactly one bit of leds is high at every clock edge and during reset.
- Elaboration-time check: WIDTH < 1 or WIDTH > 32 is a fatal error.

Test Plan:
- Reset value: WIDTH=2, rst_n=0 for 5 clocks (20 ns period) -> leds = 01 throughout, also before the first clk edge.
- Alternation: WIDTH=2, release rst_n, run 25 clocks -> leds sampled 1 ns after each rising edge = 10, 01, 10, ... (edge k gives 1<<(k mod 2)).
- Wide rotation: WIDTH=4, release reset, 9 clocks -> leds = 0010, 0100, 1000, 0001, 0010, 0100, 1000, 0001, 0010.
- Asynchronous reset mid-run: WIDTH=4 at leds=1000, drop rst_n between clock edges -> leds = 0001 within the same cycle without a clk edge. After release, the next edge gives 0010.
- Corruption recovery: WIDTH=4, force internal state to 0000 (then separately 0110) and release the force -> next rising edge gives 0001, then 0010.
- Degenerate: WIDTH=1, reset, then 5 clocks -> leds = 1 constantly.
